// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - op encodings and default latencies for the HI/LO multiply/divide unit
package mul_div_unit_pkg;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_RSVD  = 3'd7
   } md_op_e;

   localparam int MUL_LAT_DEF = 5;
   localparam int DIV_LAT_DEF = 10;
   localparam int CNT_W       = 4;

endpackage

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle MULT/DIV unit owning the architectural HI/LO registers
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int DIV_LAT = DIV_LAT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

   md_op_e            op_e;
   logic [CNT_W-1:0]  cnt;
   logic [31:0]       sh_hi;
   logic [31:0]       sh_lo;
   logic              sh_wr;

   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic               div_signed;
   logic               neg_a;
   logic               neg_b;
   logic [31:0]        mag_a;
   logic [31:0]        mag_b;
   logic [31:0]        div_b;
   logic [31:0]        q_u;
   logic [31:0]        r_u;
   logic [31:0]        quo;
   logic [31:0]        rem;

   assign op_e   = md_op_e'(op);
   assign prod_s = $signed(a) * $signed(b);
   assign prod_u = {32'd0, a} * {32'd0, b};

   // Signed divide runs on magnitudes; the quotient takes the XOR of signs and
   // the remainder follows the dividend.  A zero divisor is steered to 1 only to
   // keep the operator well defined; that result is never committed.
   assign div_signed = (op_e == OP_DIV);
   assign neg_a      = div_signed & a[31];
   assign neg_b      = div_signed & b[31];
   assign mag_a      = neg_a ? (32'd0 - a) : a;
   assign mag_b      = neg_b ? (32'd0 - b) : b;
   assign div_b      = (b == 32'd0) ? 32'd1 : mag_b;
   assign q_u        = mag_a / div_b;
   assign r_u        = mag_a % div_b;
   assign quo        = (neg_a ^ neg_b) ? (32'd0 - q_u) : q_u;
   assign rem        = neg_a ? (32'd0 - r_u) : r_u;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy  <= 1'b0;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
         sh_hi <= '0;
         sh_lo <= '0;
         sh_wr <= 1'b0;
      end else if (busy) begin
         if (flush) begin
            busy  <= 1'b0;
            cnt   <= '0;
            sh_hi <= '0;
            sh_lo <= '0;
            sh_wr <= 1'b0;
         end else if (cnt == CNT_W'(1)) begin
            busy <= 1'b0;
            cnt  <= '0;
            if (sh_wr) begin
               hi <= sh_hi;
               lo <= sh_lo;
            end
         end else begin
            cnt <= cnt - CNT_W'(1);
         end
      end else if (start && !flush) begin
         case (op_e)
            OP_MULT: begin
               busy           <= 1'b1;
               cnt            <= MUL_CNT;
               {sh_hi, sh_lo} <= prod_s;
               sh_wr          <= 1'b1;
            end
            OP_MULTU: begin
               busy           <= 1'b1;
               cnt            <= MUL_CNT;
               {sh_hi, sh_lo} <= prod_u;
               sh_wr          <= 1'b1;
            end
            OP_DIV, OP_DIVU: begin
               busy  <= 1'b1;
               cnt   <= DIV_CNT;
               sh_hi <= rem;
               sh_lo <= quo;
               sh_wr <= (b != 32'd0);
            end
            OP_MTHI: hi <= a;
            OP_MTLO: lo <= a;
            default: ;
         endcase
      end
   end

endmodule
